imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_ram.sv | 27 ++
 rtl/imem_responder.sv | 115 +++++++++++
 tb/tb_imem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory responder.
package imem_pkg;

    // Filler instruction (RISC-V "addi x0, x0, 0") returned on reset and on faulting fetches.
    localparam logic [31:0] NOP_DEFAULT = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM, DEPTH x 32; reads only update the output register when enabled.
module imem_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write on enabled write cycles, otherwise capture the addressed word into the read register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Boot-loaded instruction memory: accepts a program over a valid/ready stream, then serves fetches.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 4096,
    parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_read,
    output logic [31:0] imem_data,
    output logic        imem_ready,
    output logic        imem_fault,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        boot_done
);

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic          load_acc;
    logic          read_acc;
    logic          addr_bad;
    logic          src_ram;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_q;

    assign load_acc = load_valid && load_ready;
    assign read_acc = (state == RUN) && imem_read;
    assign addr_bad = (imem_addr[1:0] != 2'b00) || (imem_addr[31:2] >= 30'(DEPTH));

    // Loading and fetching never overlap, so one RAM port is shared between them.
    assign ram_addr = (state == RUN) ? imem_addr[AW+1:2] : wr_ptr;
    assign ram_en   = load_acc || (read_acc && !addr_bad);

    // A faulting fetch never touches the RAM; the filler word is selected instead.
    assign imem_data = src_ram ? ram_q : NOP_WORD;

    imem_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (load_acc),
        .addr (ram_addr),
        .wdata(load_data),
        .rdata(ram_q)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        boot_done  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid && (load_last || (wr_ptr == AW'(DEPTH - 1)))) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                boot_done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Load write pointer; restarts at word 0 after every reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (load_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Fetch response flags; the data source only changes when a fetch is answered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_ready <= 1'b0;
            imem_fault <= 1'b0;
            src_ram    <= 1'b0;
        end else begin
            imem_ready <= read_acc;
            imem_fault <= read_acc && addr_bad;
            if (read_acc) begin
                src_ram <= !addr_bad;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder with an array-based memory reference model.
module tb_imem_responder;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        imem_fault;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        boot_done;

    imem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_read (imem_read),
        .imem_data (imem_data),
        .imem_ready(imem_ready),
        .imem_fault(imem_fault),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .boot_done (boot_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: memory image, load pointer, whether fetch service is active.
    logic [31:0] model_mem [DEPTH];
    int          model_wr;
    int          hi_written;
    bit          model_run;

    // Expected responses: {fault, data}.
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [32:0] expect_rd(input logic [31:0] a);
        if ((a % 4) != 0 || (a / 4) >= DEPTH) return {1'b1, NOP};
        return {1'b0, model_mem[a / 4]};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int m;
        m = $urandom_range(0, 9);
        if (m < 7) begin
            a = 32'($urandom_range(0, hi_written - 1)) << 2;
        end else if (m == 7) begin
            a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        end else begin
            a = $urandom;
            if ((a / 4) < DEPTH) a[31] = 1'b1;
        end
        return a;
    endfunction

    // Monitor: every presented response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(imem_ready), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rd_data", imem_data, mon_e[31:0]);
                    chk("rd_fault", 32'(imem_fault), 32'(mon_e[32]));
                end
            end else begin
                chk("fault_without_ready", 32'(imem_fault), 32'd0);
            end
        end
    end

    task automatic issue_read(input logic [31:0] a);
        imem_read = 1'b1;
        imem_addr = a;
        if (model_run) exp_q.push_back(expect_rd(a));
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last, input int gap);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk);
        model_mem[model_wr] = d;
        if (last || model_wr == DEPTH - 1) model_run = 1'b1;
        model_wr++;
        if (model_wr > hi_written) hi_written = model_wr;
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = $urandom;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        imem_read = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        imem_read  = 1'b0;
        load_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_data", imem_data, NOP);
        chk("rst_ready", 32'(imem_ready), 32'd0);
        chk("rst_fault", 32'(imem_fault), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        exp_q.delete();
        model_run = 1'b0;
        model_wr  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("idle_load_ready", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("load_ready_after_release", 32'(load_ready), 32'd1);
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                issue_read(rand_addr());
            end else begin
                imem_read = 1'b0;
                imem_addr = $urandom;
                @(posedge clk);
                #1;
            end
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        reset      = 1'b1;
        imem_read  = 1'b0;
        imem_addr  = '0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        model_wr   = 0;
        hi_written = 0;
        model_run  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("por_data", imem_data, NOP);
        chk("por_ready", 32'(imem_ready), 32'd0);
        chk("por_load_ready", 32'(load_ready), 32'd0);
        chk("por_boot_done", 32'(boot_done), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_load_ready", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("load_ready_after_release", 32'(load_ready), 32'd1);

        // Short program; fetch requests while loading must be ignored.
        imem_read = 1'b1;
        imem_addr = 32'h0;
        load_word(32'h00000013, 1'b0, 0);
        load_word(32'h00100093, 1'b0, 0);
        chk("ready_during_load", 32'(imem_ready), 32'd0);
        imem_read = 1'b0;
        load_word(32'h00200113, 1'b1, 0);
        chk("boot_done_after_last", 32'(boot_done), 32'd1);
        chk("load_ready_in_run", 32'(load_ready), 32'd0);

        issue_read(32'h4);
        drain();
        issue_read(32'h0);
        issue_read(32'h4);
        issue_read(32'h8);
        drain();

        // Faults, then an idle cycle clears ready and fault while data holds.
        issue_read(32'h6);
        issue_read(32'h4000);
        imem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(imem_ready), 32'd0);
        chk("idle_fault", 32'(imem_fault), 32'd0);
        chk("idle_data_hold", imem_data, NOP);

        // Load offers in RUN are ignored and must not modify memory.
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("load_ready_run_ignored", 32'(load_ready), 32'd0);
        end
        load_valid = 1'b0;
        random_reads(100);

        // Fill the whole memory without load_last; RUN must follow the final word.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word($urandom, 1'b0, ($urandom_range(0, 7) == 0) ? 1 : 0);
            chk("boot_done_overflow", 32'(boot_done), 32'(model_run));
        end
        random_reads(400);
        issue_read(32'h3FFC);
        drain();

        // Reset mid-RUN and reload a short program over the start of memory.
        do_reset();
        load_word($urandom, 1'b0, 1);
        load_word($urandom, 1'b0, 0);
        load_word($urandom, 1'b1, 0);
        chk("boot_done_reload", 32'(boot_done), 32'd1);
        issue_read(32'h0);
        issue_read(32'h8);
        issue_read(32'hC);
        issue_read(32'h1000);
        issue_read(32'h3FFC);
        drain();
        random_reads(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
